mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 146 ++++++++++++++
 tb/tb_mem_stage.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory access stage: latches one EX result, runs a req/addr_ok/data_ok
// handshake with the data SRAM, and hands the aligned result to WB.
module mem_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic         EX_to_MEM_valid,
    output logic         MEM_allow_in,
    input  logic [106:0] to_MEM_data,
    input  logic         WB_allow_in,
    output logic         MEM_to_WB_valid,
    output logic [69:0]  to_WB_data,
    output logic         MEM_ale,
    output logic         data_sram_req,
    output logic         data_sram_wr,
    output logic [1:0]   data_sram_size,
    output logic [3:0]   data_sram_wstrb,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata,
    input  logic         data_sram_addr_ok,
    input  logic         data_sram_data_ok,
    input  logic [31:0]  data_sram_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [106:0]  bus_q, bus_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [31:0]   pc, alu_result, rkd_value;
    logic [1:0]    mem_size;
    logic          mem_sign_ext, mem_we, res_from_mem, gr_we;
    logic [4:0]    dest;

    assign pc           = bus_q[106:75];
    assign alu_result   = bus_q[74:43];
    assign rkd_value    = bus_q[42:11];
    assign mem_size     = bus_q[10:9];
    assign mem_sign_ext = bus_q[8];
    assign mem_we       = bus_q[7];
    assign res_from_mem = bus_q[6];
    assign dest         = bus_q[5:1];
    assign gr_we        = bus_q[0];

    function automatic logic misalign_f(input logic [1:0] sz,
                                        input logic [1:0] a);
        return ((sz == 2'd1) && a[0]) || (sz[1] && (a != 2'b00));
    endfunction

    logic accept;
    logic in_mem, in_mis;
    logic is_mem, mis;

    assign in_mem = to_MEM_data[7] | to_MEM_data[6];
    assign in_mis = misalign_f(to_MEM_data[10:9], to_MEM_data[44:43]);
    assign is_mem = mem_we | res_from_mem;
    assign mis    = is_mem & misalign_f(mem_size, alu_result[1:0]);

    assign MEM_allow_in = (state_q == IDLE) ||
                          ((state_q == DONE) && WB_allow_in);
    assign accept       = EX_to_MEM_valid & MEM_allow_in;

    always_comb begin
        state_d = state_q;
        bus_d   = bus_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: state_d = IDLE;
            REQ:  if (data_sram_addr_ok) state_d = WAIT;
            WAIT: begin
                if (data_sram_data_ok) begin
                    rdata_d = data_sram_rdata;
                    state_d = DONE;
                end
            end
            DONE: if (WB_allow_in) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Accept overrides the DONE->IDLE retire so back-to-back flows.
        if (accept) begin
            bus_d   = to_MEM_data;
            state_d = (in_mem && !in_mis) ? REQ : DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            bus_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            bus_q   <= bus_d;
            rdata_q <= rdata_d;
        end
    end

    assign data_sram_req  = (state_q == REQ);
    assign data_sram_wr   = mem_we;
    assign data_sram_addr = alu_result;
    assign data_sram_size = (mem_size == 2'd3) ? 2'd2 : mem_size;

    always_comb begin
        data_sram_wstrb = 4'b0000;
        data_sram_wdata = rkd_value;
        unique case (data_sram_size)
            2'd0: begin
                data_sram_wdata = {4{rkd_value[7:0]}};
                if (mem_we) data_sram_wstrb = 4'b0001 << alu_result[1:0];
            end
            2'd1: begin
                data_sram_wdata = {2{rkd_value[15:0]}};
                if (mem_we) data_sram_wstrb = 4'b0011 << {alu_result[1], 1'b0};
            end
            default: begin
                data_sram_wdata = rkd_value;
                if (mem_we) data_sram_wstrb = 4'b1111;
            end
        endcase
    end

    logic [31:0] shifted, load_data, final_result;

    assign shifted = rdata_q >> {alu_result[1:0], 3'b000};

    always_comb begin
        load_data = shifted;
        unique case (data_sram_size)
            2'd0: load_data = {{24{mem_sign_ext & shifted[7]}}, shifted[7:0]};
            2'd1: load_data = {{16{mem_sign_ext & shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    assign final_result = (res_from_mem && !mis) ? load_data : alu_result;

    assign MEM_ale         = (state_q != IDLE) && mis;
    assign MEM_to_WB_valid = (state_q == DONE);
    assign to_WB_data      = {pc, final_result, dest, gr_we & ~mis};

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         EX_to_MEM_valid;
    logic         MEM_allow_in;
    logic [106:0] to_MEM_data;
    logic         WB_allow_in;
    logic         MEM_to_WB_valid;
    logic [69:0]  to_WB_data;
    logic         MEM_ale;
    logic         data_sram_req;
    logic         data_sram_wr;
    logic [1:0]   data_sram_size;
    logic [3:0]   data_sram_wstrb;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic         data_sram_addr_ok;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk),
        .reset(reset),
        .EX_to_MEM_valid(EX_to_MEM_valid),
        .MEM_allow_in(MEM_allow_in),
        .to_MEM_data(to_MEM_data),
        .WB_allow_in(WB_allow_in),
        .MEM_to_WB_valid(MEM_to_WB_valid),
        .to_WB_data(to_WB_data),
        .MEM_ale(MEM_ale),
        .data_sram_req(data_sram_req),
        .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size),
        .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr),
        .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok),
        .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata)
    );

    function automatic logic [106:0] mk(
        input logic [31:0] pc, input logic [31:0] alu,
        input logic [31:0] rkd, input logic [1:0] sz,
        input logic sx, input logic we, input logic rfm,
        input logic [4:0] dst, input logic gw);
        return {pc, alu, rkd, sz, sx, we, rfm, dst, gw};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        EX_to_MEM_valid = 1'b0;
        to_MEM_data = '0;
        WB_allow_in = 1'b1;
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata = '0;
        step(); step();
        reset = 1'b0;
        #1;
        tests++;
        if (MEM_allow_in !== 1'b1) begin
            fails++; $display("FAIL rst_allow: got %b want 1", MEM_allow_in);
        end
        tests++;
        if (MEM_to_WB_valid !== 1'b0) begin
            fails++; $display("FAIL rst_valid: got %b want 0", MEM_to_WB_valid);
        end
        tests++;
        if (data_sram_req !== 1'b0) begin
            fails++; $display("FAIL rst_req: got %b want 0", data_sram_req);
        end
        tests++;
        if (MEM_ale !== 1'b0) begin
            fails++; $display("FAIL rst_ale: got %b want 0", MEM_ale);
        end
        tests++;
        if (to_WB_data !== 70'd0) begin
            fails++; $display("FAIL rst_bus: got %h want 0", to_WB_data);
        end
    endtask

    task automatic test_alu();
        logic [69:0] exp;
        exp = {32'h0000_0100, 32'h0000_1234, 5'd3, 1'b1};
        step();
        EX_to_MEM_valid = 1'b1;
        WB_allow_in = 1'b1;
        to_MEM_data = mk(32'h100, 32'h1234, 32'h0, 2'd2, 1'b0,
                         1'b0, 1'b0, 5'd3, 1'b1);
        step();
        EX_to_MEM_valid = 1'b0;
        #1;
        tests++;
        if (MEM_to_WB_valid !== 1'b1) begin
            fails++; $display("FAIL alu_valid: got %b want 1", MEM_to_WB_valid);
        end
        tests++;
        if (to_WB_data !== exp) begin
            fails++; $display("FAIL alu_data: got %h want %h", to_WB_data, exp);
        end
        tests++;
        if (data_sram_req !== 1'b0) begin
            fails++; $display("FAIL alu_noreq: got %b want 0", data_sram_req);
        end
        step(); #1;
        tests++;
        if (MEM_to_WB_valid !== 1'b0) begin
            fails++; $display("FAIL alu_once: got %b want 0", MEM_to_WB_valid);
        end
    endtask

    task automatic test_ld_b();
        step();
        EX_to_MEM_valid = 1'b1;
        WB_allow_in = 1'b1;
        to_MEM_data = mk(32'h200, 32'h1003, 32'hDEAD_BEEF, 2'd0, 1'b1,
                         1'b0, 1'b1, 5'd4, 1'b1);
        step();
        EX_to_MEM_valid = 1'b0;
        #1;
        tests++;
        if ({data_sram_req, data_sram_wr, data_sram_size,
             data_sram_wstrb} !== 8'b1_0_00_0000) begin
            fails++; $display("FAIL ldb_req: got %b%b %0d %b want 1 0 0 0000",
                data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb);
        end
        tests++;
        if (data_sram_addr !== 32'h1003) begin
            fails++; $display("FAIL ldb_addr: got %h want 1003", data_sram_addr);
        end
        tests++;
        if (MEM_allow_in !== 1'b0) begin
            fails++; $display("FAIL ldb_allow: got %b want 0", MEM_allow_in);
        end
        data_sram_addr_ok = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h1111_1111;
        step();
        data_sram_addr_ok = 1'b0;
        data_sram_rdata = 32'h80FF_FF00;
        #1;
        tests++;
        if (data_sram_req !== 1'b0 || MEM_to_WB_valid !== 1'b0) begin
            fails++; $display("FAIL ldb_wait: got req %b valid %b want 0 0",
                data_sram_req, MEM_to_WB_valid);
        end
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata = 32'h0;
        #1;
        tests++;
        if (MEM_to_WB_valid !== 1'b1) begin
            fails++; $display("FAIL ldb_valid: got %b want 1", MEM_to_WB_valid);
        end
        tests++;
        if (to_WB_data !== {32'h200, 32'hFFFF_FF80, 5'd4, 1'b1}) begin
            fails++; $display("FAIL ldb_data: got %h want %h", to_WB_data,
                {32'h200, 32'hFFFF_FF80, 5'd4, 1'b1});
        end
        step(); #1;
        tests++;
        if (MEM_to_WB_valid !== 1'b0) begin
            fails++; $display("FAIL ldb_retire: got %b want 0", MEM_to_WB_valid);
        end
    endtask

    task automatic test_load_ext();
        logic [31:0] addr[4] = '{32'h5002, 32'h5002, 32'h5001, 32'h5000};
        logic [1:0]  sz[4]   = '{2'd1, 2'd1, 2'd0, 2'd3};
        logic        sx[4]   = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] exp[4]  = '{32'h0000_8765, 32'hFFFF_8765,
                                 32'h0000_0043, 32'h8765_4321};
        for (int i = 0; i < 4; i++) begin
            step();
            EX_to_MEM_valid = 1'b1;
            to_MEM_data = mk(32'h500, addr[i], 32'h0, sz[i], sx[i],
                             1'b0, 1'b1, 5'd6, 1'b1);
            step();
            EX_to_MEM_valid = 1'b0;
            data_sram_addr_ok = 1'b1;
            step();
            data_sram_addr_ok = 1'b0;
            data_sram_data_ok = 1'b1;
            data_sram_rdata = 32'h8765_4321;
            step();
            data_sram_data_ok = 1'b0;
            #1;
            tests++;
            if (MEM_to_WB_valid !== 1'b1 || to_WB_data[37:6] !== exp[i]) begin
                fails++; $display("FAIL ldext%0d: got v%b %h want v1 %h", i,
                    MEM_to_WB_valid, to_WB_data[37:6], exp[i]);
            end
        end
        step();
    endtask

    task automatic test_st_h();
        step();
        EX_to_MEM_valid = 1'b1;
        WB_allow_in = 1'b1;
        to_MEM_data = mk(32'h300, 32'h2002, 32'hAAAA_BEEF, 2'd1, 1'b0,
                         1'b1, 1'b0, 5'd0, 1'b1);
        step();
        EX_to_MEM_valid = 1'b0;
        #1;
        tests++;
        if ({data_sram_req, data_sram_wr, data_sram_size,
             data_sram_wstrb} !== 8'b1_1_01_1100) begin
            fails++; $display("FAIL sth_req: got %b%b %0d %b want 1 1 1 1100",
                data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb);
        end
        tests++;
        if (data_sram_wdata !== 32'hBEEF_BEEF) begin
            fails++; $display("FAIL sth_wdata: got %h want beefbeef",
                data_sram_wdata);
        end
        data_sram_addr_ok = 1'b1;
        step();
        data_sram_addr_ok = 1'b0;
        step(); #1;
        tests++;
        if (MEM_to_WB_valid !== 1'b0) begin
            fails++; $display("FAIL sth_wait: got %b want 0", MEM_to_WB_valid);
        end
        data_sram_data_ok = 1'b1;
        step();
        data_sram_data_ok = 1'b0;
        #1;
        tests++;
        if (MEM_to_WB_valid !== 1'b1 ||
            to_WB_data !== {32'h300, 32'h2002, 5'd0, 1'b1}) begin
            fails++; $display("FAIL sth_done: got v%b %h want v1 %h",
                MEM_to_WB_valid, to_WB_data, {32'h300, 32'h2002, 5'd0, 1'b1});
        end
        step();
    endtask

    task automatic test_ale();
        step();
        EX_to_MEM_valid = 1'b1;
        WB_allow_in = 1'b0;
        to_MEM_data = mk(32'h400, 32'h3001, 32'h0, 2'd2, 1'b0,
                         1'b0, 1'b1, 5'd7, 1'b1);
        step();
        EX_to_MEM_valid = 1'b0;
        #1;
        tests++;
        if (data_sram_req !== 1'b0 || MEM_ale !== 1'b1) begin
            fails++; $display("FAIL ale_flag: got req %b ale %b want 0 1",
                data_sram_req, MEM_ale);
        end
        tests++;
        if (MEM_to_WB_valid !== 1'b1 ||
            to_WB_data !== {32'h400, 32'h3001, 5'd7, 1'b0}) begin
            fails++; $display("FAIL ale_data: got v%b %h want v1 %h",
                MEM_to_WB_valid, to_WB_data, {32'h400, 32'h3001, 5'd7, 1'b0});
        end
        WB_allow_in = 1'b1;
        step(); #1;
        tests++;
        if (MEM_ale !== 1'b0 || MEM_to_WB_valid !== 1'b0) begin
            fails++; $display("FAIL ale_clear: got ale %b v %b want 0 0",
                MEM_ale, MEM_to_WB_valid);
        end
    endtask

    task automatic test_stall();
        logic [69:0] exp;
        exp = {32'h600, 32'h4000, 5'd9, 1'b0};
        step();
        EX_to_MEM_valid = 1'b1;
        WB_allow_in = 1'b0;
        to_MEM_data = mk(32'h600, 32'h4000, 32'h1122_3344, 2'd3, 1'b0,
                         1'b1, 1'b0, 5'd9, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            EX_to_MEM_valid = 1'b0;
            data_sram_data_ok = 1'b1;
            #1;
            tests++;
            if (data_sram_req !== 1'b1 || data_sram_addr !== 32'h4000 ||
                data_sram_wdata !== 32'h1122_3344 ||
                data_sram_wstrb !== 4'b1111 || data_sram_size !== 2'd2 ||
                MEM_allow_in !== 1'b0) begin
                fails++; $display("FAIL stall_req%0d: got r%b %h %h %b %0d a%b",
                    i, data_sram_req, data_sram_addr, data_sram_wdata,
                    data_sram_wstrb, data_sram_size, MEM_allow_in);
            end
        end
        data_sram_data_ok = 1'b0;
        data_sram_addr_ok = 1'b1;
        step();
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b1;
        step();
        data_sram_data_ok = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests++;
            if (MEM_to_WB_valid !== 1'b1 || MEM_allow_in !== 1'b0 ||
                to_WB_data !== exp) begin
                fails++; $display("FAIL stall_hold%0d: got v%b a%b %h want %h",
                    i, MEM_to_WB_valid, MEM_allow_in, to_WB_data, exp);
            end
            step();
        end
        WB_allow_in = 1'b1;
        #1;
        tests++;
        if (MEM_allow_in !== 1'b1) begin
            fails++; $display("FAIL stall_release: got %b want 1", MEM_allow_in);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [69:0] ea, eb;
        ea = {32'h700, 32'hAAAA_0001, 5'd1, 1'b1};
        eb = {32'h704, 32'hBBBB_0002, 5'd2, 1'b1};
        step();
        EX_to_MEM_valid = 1'b1;
        WB_allow_in = 1'b1;
        to_MEM_data = mk(32'h700, 32'hAAAA_0001, 32'h0, 2'd0, 1'b0,
                         1'b0, 1'b0, 5'd1, 1'b1);
        step();
        to_MEM_data = mk(32'h704, 32'hBBBB_0002, 32'h0, 2'd0, 1'b0,
                         1'b0, 1'b0, 5'd2, 1'b1);
        #1;
        tests++;
        if (MEM_to_WB_valid !== 1'b1 || MEM_allow_in !== 1'b1 ||
            to_WB_data !== ea) begin
            fails++; $display("FAIL b2b_a: got v%b a%b %h want %h",
                MEM_to_WB_valid, MEM_allow_in, to_WB_data, ea);
        end
        step();
        EX_to_MEM_valid = 1'b0;
        #1;
        tests++;
        if (MEM_to_WB_valid !== 1'b1 || to_WB_data !== eb) begin
            fails++; $display("FAIL b2b_b: got v%b %h want %h",
                MEM_to_WB_valid, to_WB_data, eb);
        end
        step();
    endtask

    task automatic test_reset_wait();
        step();
        EX_to_MEM_valid = 1'b1;
        WB_allow_in = 1'b1;
        to_MEM_data = mk(32'h800, 32'h6000, 32'h0, 2'd2, 1'b0,
                         1'b0, 1'b1, 5'd8, 1'b1);
        step();
        EX_to_MEM_valid = 1'b0;
        data_sram_addr_ok = 1'b1;
        step();
        data_sram_addr_ok = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'hCAFE_F00D;
        #1;
        tests++;
        if (MEM_to_WB_valid !== 1'b0 || MEM_allow_in !== 1'b1 ||
            data_sram_req !== 1'b0) begin
            fails++; $display("FAIL rstw_abort: got v%b a%b r%b want 0 1 0",
                MEM_to_WB_valid, MEM_allow_in, data_sram_req);
        end
        step();
        data_sram_data_ok = 1'b0;
        #1;
        tests++;
        if (MEM_to_WB_valid !== 1'b0 || MEM_allow_in !== 1'b1) begin
            fails++; $display("FAIL rstw_ignore: got v%b a%b want 0 1",
                MEM_to_WB_valid, MEM_allow_in);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_ld_b();
        test_load_ext();
        test_st_h();
        test_ale();
        test_stall();
        test_back_to_back();
        test_reset_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
